// File: rtl/apb3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb3_pkg
// Description : Shared types and constants for the APB3 initiator.
// Revision    : 1.0  initial release
// ============================================================================
package apb3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb3_state_e;

  localparam int c_data_w      = 32;
  localparam int c_def_addr_w  = 8;
  localparam int c_def_timeout = 16;

endpackage
`default_nettype wire

// File: rtl/apb3_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : apb3_wait_timer
// Description : Saturating ACCESS wait-state counter with timeout flag.
// Revision    : 1.0  initial release
// ============================================================================
module apb3_wait_timer
  import apb3_pkg::*;
#(
  parameter int TIMEOUT = c_def_timeout
) (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      localparam int c_cnt_w = $clog2(TIMEOUT + 1);
      localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);
      localparam logic [c_cnt_w-1:0] c_max  = c_cnt_w'(TIMEOUT);

      logic [c_cnt_w-1:0] r_count;

      always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
          r_count <= '0;
        end else if (clear) begin
          r_count <= '0;
        end else if (enable && (r_count != c_max)) begin
          r_count <= r_count + 1'b1;
        end
      end

      // Flags the last permitted wait cycle; the master lets PREADY win here.
      assign expired = (r_count == c_last);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/apb3_master.sv
`default_nettype none
// ============================================================================
// Module      : apb3_master
// Description : Single-word request/response to APB3 initiator with timeout.
// Revision    : 1.0  initial release
// ============================================================================
module apb3_master
  import apb3_pkg::*;
#(
  parameter int ADDR_W  = c_def_addr_w,
  parameter int TIMEOUT = c_def_timeout
) (
  input  logic                PCLK,
  input  logic                PRESETN,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [c_data_w-1:0] cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [c_data_w-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [c_data_w-1:0] PWDATA,
  input  logic [c_data_w-1:0] PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  apb3_state_e         r_state;
  logic                r_cmd_ready;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [c_data_w-1:0] r_pwdata;
  logic                r_rsp_valid;
  logic [c_data_w-1:0] r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_rsp_timeout;

  logic w_accept;
  logic w_misaligned;
  logic w_expired;

  assign w_accept     = (r_state == ST_IDLE) && r_cmd_ready && cmd_valid;
  assign w_misaligned = (cmd_addr[1:0] != 2'b00);

  apb3_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .clear   (w_accept),
    .enable  ((r_state == ST_ACCESS) && !PREADY),
    .expired (w_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_pwrite    <= cmd_write;
            r_paddr     <= cmd_addr;
            r_pwdata    <= cmd_wdata;
            if (w_misaligned) begin
              // Misaligned requests are answered locally without touching the bus.
              r_state       <= ST_RESP;
              r_rsp_valid   <= 1'b1;
              r_rsp_rdata   <= '0;
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b0;
            end else begin
              r_state <= ST_SETUP;
              r_psel  <= 1'b1;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            r_state       <= ST_RESP;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= (!r_pwrite && !PSLVERR) ? PRDATA : '0;
            r_rsp_err     <= PSLVERR;
            r_rsp_timeout <= 1'b0;
          end else if (w_expired) begin
            r_state       <= ST_RESP;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb3_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb3_master
// Description : Directed self-checking bench for apb3_master.
// Revision    : 1.0  initial release
// ============================================================================
module tb_apb3_master;

  logic        PCLK;
  logic        PRESETN;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  apb3_master #(
    .ADDR_W  (8),
    .TIMEOUT (16)
  ) dut (
    .PCLK        (PCLK),
    .PRESETN     (PRESETN),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, rsp_valid, 1'b0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    PRESETN   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_psel",      PSEL,        1'b0);
    chk("rst_penable",   PENABLE,     1'b0);
    chk("rst_pwrite",    PWRITE,      1'b0);
    chk("rst_paddr",     PADDR,       8'h00);
    chk("rst_pwdata",    PWDATA,      32'h0);
    chk("rst_rsp_valid", rsp_valid,   1'b0);
    chk("rst_rsp_err",   rsp_err,     1'b0);
    chk("rst_rsp_to",    rsp_timeout, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata,   32'h0);
    chk("rst_cmd_ready", cmd_ready,   1'b0);
    PRESETN = 1'b1;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Write, zero wait states
    PREADY = 1'b1;
    issue(1'b1, 8'h08, 32'hDEADBEEF);
    chk("wr_setup_psel",    PSEL,      1'b1);
    chk("wr_setup_penable", PENABLE,   1'b0);
    chk("wr_setup_paddr",   PADDR,     8'h08);
    chk("wr_setup_pwrite",  PWRITE,    1'b1);
    chk("wr_setup_ready",   cmd_ready, 1'b0);
    tick();
    chk("wr_access_penable", PENABLE, 1'b1);
    chk("wr_access_pwdata",  PWDATA,  32'hDEADBEEF);
    chk("wr_access_rvalid",  rsp_valid, 1'b0);
    tick();
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_err",   rsp_err,   1'b0);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_rsp_psel",  PSEL,      1'b0);
    chk("wr_hold_paddr", PADDR,    8'h08);
    consume("wr");

    // Read with 3 wait states
    PREADY = 1'b0;
    PRDATA = 32'h12345678;
    issue(1'b0, 8'h0C, 32'h0);
    tick();
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      if (PENABLE === 1'b1) cyc++;
      tick();
    end
    if (PENABLE === 1'b1) cyc++;
    PREADY = 1'b1;
    tick();
    chk("rd_ws_penable_cycles", cyc, 4);
    chk("rd_ws_rsp_valid", rsp_valid, 1'b1);
    chk("rd_ws_rdata",     rsp_rdata, 32'h12345678);
    chk("rd_ws_err",       rsp_err,   1'b0);
    consume("rd_ws");

    // Read with PSLVERR
    PSLVERR = 1'b1;
    PRDATA  = 32'hAAAA5555;
    issue(1'b0, 8'h10, 32'h0);
    tick();
    tick();
    chk("slverr_valid",   rsp_valid,   1'b1);
    chk("slverr_err",     rsp_err,     1'b1);
    chk("slverr_timeout", rsp_timeout, 1'b0);
    chk("slverr_rdata",   rsp_rdata,   32'h0);
    consume("slverr");
    PSLVERR = 1'b0;

    // Timeout: PREADY never arrives
    PREADY = 1'b0;
    issue(1'b0, 8'h14, 32'h0);
    tick();
    cyc = 0;
    while (PENABLE === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("to_access_cycles", cyc, 16);
    chk("to_valid",   rsp_valid,   1'b1);
    chk("to_err",     rsp_err,     1'b1);
    chk("to_timeout", rsp_timeout, 1'b1);
    chk("to_rdata",   rsp_rdata,   32'h0);
    chk("to_psel",    PSEL,        1'b0);
    consume("to");

    // PREADY in the final permitted ACCESS cycle beats the timeout
    PRDATA = 32'hCAFEF00D;
    issue(1'b0, 8'h18, 32'h0);
    tick();
    repeat (15) tick();
    chk("edge_penable", PENABLE, 1'b1);
    PREADY = 1'b1;
    tick();
    chk("edge_valid",   rsp_valid,   1'b1);
    chk("edge_err",     rsp_err,     1'b0);
    chk("edge_timeout", rsp_timeout, 1'b0);
    chk("edge_rdata",   rsp_rdata,   32'hCAFEF00D);
    consume("edge");

    // rsp_ready while idle is ignored
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("idle_rready_valid", rsp_valid, 1'b0);
    chk("idle_rready_ready", cmd_ready, 1'b1);

    // Misaligned, then backpressure on the response
    issue(1'b1, 8'h05, 32'h11111111);
    chk("mis_valid",   rsp_valid,   1'b1);
    chk("mis_err",     rsp_err,     1'b1);
    chk("mis_timeout", rsp_timeout, 1'b0);
    chk("mis_psel",    PSEL,        1'b0);
    cmd_valid = 1'b1;
    cmd_addr  = 8'h20;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_err",   rsp_err,   1'b1);
      chk("bp_ready", cmd_ready, 1'b0);
      chk("bp_psel",  PSEL,      1'b0);
    end
    cmd_valid = 1'b0;
    consume("mis");

    // Reset during ACCESS
    PREADY = 1'b0;
    issue(1'b0, 8'h20, 32'h0);
    tick();
    chk("mid_pre_penable", PENABLE, 1'b1);
    PRESETN = 1'b0;
    #1;
    chk("mid_rst_psel",    PSEL,    1'b0);
    chk("mid_rst_penable", PENABLE, 1'b0);
    tick();
    tick();
    PRESETN = 1'b1;
    chk("mid_rst_rvalid", rsp_valid, 1'b0);
    tick();
    chk("mid_rel_ready",  cmd_ready, 1'b1);
    chk("mid_rel_rvalid", rsp_valid, 1'b0);
    PREADY = 1'b1;
    PRDATA = 32'h0BADF00D;
    issue(1'b0, 8'h24, 32'h0);
    chk("post_setup_paddr", PADDR, 8'h24);
    tick();
    tick();
    chk("post_valid", rsp_valid, 1'b1);
    chk("post_rdata", rsp_rdata, 32'h0BADF00D);
    chk("post_err",   rsp_err,   1'b0);
    consume("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb3_master.md
# apb3_master

Fabric-side APB3 initiator that turns single-word requests from an on-fabric requester (RSA sequencer, NFC handler) into APB3 transfers on the peripheral bus decoded by the team's APB3 slave interface. It owns the SETUP/ACCESS sequencing, honours PREADY wait states and PSLVERR, and enforces a wait-state timeout. It also returns each result through a valid/ready response channel.

## Interface
- ADDR_W, 8, APB address width (PADDR, cmd_addr).
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout.
- PCLK  input  1  bus clock; all logic on its rising edge.
- PRESETN  input  1  asynchronous active-low reset.
- cmd_valid  input  1  request present.
- cmd_ready  output  1  request accepted when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  byte address; must be word-aligned.
- cmd_wdata  input  32  write data.
- rsp_valid  output  1  response present; held until rsp_ready.
- rsp_ready  input  1  requester consumes the response.
- rsp_rdata  output  32  read data; 0 for writes and errors.
- rsp_err  output  1  PSLVERR, timeout or misalignment.
- rsp_timeout  output  1  abort caused by timeout.
- PSEL, PENABLE, PWRITE  output  1  APB3 control.
- PADDR  output  ADDR_W  APB3 address.
- PWDATA  output  32  APB3 write data.
- PRDATA  input  32  APB3 read data.
- PREADY, PSLVERR  input  1  APB3 completion and error.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready = 1 (0 while PRESETN low). On accept, register cmd_write/cmd_addr/cmd_wdata.
  - cmd_addr[1:0] != 0 -> RESP with err=1, timeout=0, no bus activity.
  - Otherwise -> SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from registers; always -> ACCESS after one cycle.
- ACCESS: PSEL=1, PENABLE=1. Each cycle:
  - If PREADY: capture PRDATA (reads only) and PSLVERR into rsp_err -> RESP.
  - Else increment wait counter. At count TIMEOUT-1 without PREADY -> RESP with err=1, timeout=1, rdata=0.
- RESP: PSEL=PENABLE=0, rsp_valid=1, response fields stable. On rsp_ready -> IDLE.
- PADDR, PWRITE and PWDATA hold their values from SETUP through the end of ACCESS. They are not cleared afterwards; they change only at the next accept.
- Wait counter is cleared on entry to SETUP and is width $clog2(TIMEOUT+1). It saturates and never wraps.
- Reset mid-transfer drops PSEL/PENABLE asynchronously and discards any pending response; state returns to IDLE.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout = 0; PADDR, PWDATA, rsp_rdata = 0; cmd_ready = 0 until PRESETN deasserts, then 1.
- Accept at cycle N -> SETUP at N+1 -> ACCESS at N+2.
- With PREADY=1 at N+2, rsp_valid rises at N+3. Each wait state adds one cycle.
- With rsp_ready held high: 4 cycles per transfer. Next accept occurs in the IDLE cycle after the response handshake.
- Misaligned request: rsp_valid at N+1.
- Timeout: PREADY low for TIMEOUT ACCESS cycles -> rsp_valid asserts the next cycle. PREADY arriving in that final ACCESS cycle still wins over the timeout.
- rsp_ready asserted while rsp_valid is low is ignored.

## Structure
- Package apb3_pkg: state enum (IDLE, SETUP, ACCESS, RESP), APB data width 32, default ADDR_W, default TIMEOUT.
- Sub-module apb3_wait_timer: clear/enable inputs, expired output, saturating counter. Everything else lives in apb3_master.

## Test plan
- Write addr 0x08, data 0xDEADBEEF, PREADY=1 -> PSEL at N+1, PENABLE at N+2 with PWDATA=0xDEADBEEF, rsp_valid at N+3 with err=0, rdata=0.
- Read addr 0x0C, PREADY low 3 cycles, PRDATA=0x12345678 -> PENABLE high 4 cycles, rsp_rdata=0x12345678, err=0.
- Read with PSLVERR=1 and PREADY=1 -> rsp_err=1, rsp_timeout=0.
- TIMEOUT=16, PREADY never asserted -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, PSEL low.
- cmd_addr=0x05 -> no PSEL pulse, rsp_valid at N+1 with err=1. Separately, hold rsp_ready low 5 cycles -> response stable and cmd_ready=0 throughout.
- Deassert PRESETN during ACCESS -> PSEL/PENABLE low immediately, no rsp_valid; after release a new read completes normally.
